// File: rtl/fft64_twiddle_sched.sv
// Twiddle sequencing controller for one radix-2 DIF stage of a 64-point FFT.
// Tracks the in-frame index, derives W64^k per sample and drives a shared multiplier through a 2-deep pipeline.
module fft64_twiddle_sched #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cfg_stage,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic [DW-1:0] mul_a,
  output logic [4:0]    mul_tw_idx,
  input  logic [DW-1:0] mul_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          frame_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q;
  logic [5:0]    n_q;
  logic [2:0]    s_q;
  logic          frame_err_q;

  logic          s1_valid_q;
  logic [DW-1:0] mul_a_q;
  logic [4:0]    tw_q;
  logic          s1_byp_q;
  logic          s1_last_q;

  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_last_q;

  logic          s2_adv_s;
  logic          s1_adv_s;
  logic          accept_s;
  logic [2:0]    cfg_sat_s;
  logic [2:0]    s_eff_s;
  logic [4:0]    k_d;
  logic          byp_d;
  logic          last_d;

  // Returns {bypass, k}: the first half of each butterfly group passes through untouched.
  function automatic logic [5:0] twiddle(input logic [5:0] n, input logic [2:0] s);
    logic [5:0] gm1;
    logic [5:0] h;
    logic [5:0] p;
    logic [4:0] k;
    gm1 = 6'd63 >> s;
    h   = 6'd32 >> s;
    p   = n & gm1;
    if (p < h) begin
      return {1'b1, 5'd0};
    end else begin
      k = 5'((p - h) << s);
      return {(k == 5'd0), k};
    end
  endfunction

  assign s2_adv_s  = !out_valid_q || out_ready;
  assign s1_adv_s  = !s1_valid_q || s2_adv_s;
  assign in_ready  = s1_adv_s && !rst;
  assign accept_s  = in_valid && in_ready;
  assign cfg_sat_s = (cfg_stage > 3'd5) ? 3'd5 : cfg_stage;
  assign s_eff_s   = (n_q == 6'd0) ? cfg_sat_s : s_q;
  assign last_d    = (n_q == 6'd63);
  assign {byp_d, k_d} = twiddle(n_q, s_eff_s);

  // Frame tracking: index counter, stage latch and in_last consistency check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= 6'd0;
      s_q         <= 3'd0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (accept_s) begin
        frame_err_q <= in_last ^ last_d;
        if (n_q == 6'd0) begin
          s_q <= cfg_sat_s;
        end
        // An early in_last resyncs the count so the next beat starts a new frame.
        n_q <= (in_last || last_d) ? 6'd0 : n_q + 6'd1;
        case (state_q)
          ST_IDLE: state_q <= (in_last || last_d) ? ST_IDLE : ST_RUN;
          ST_RUN:  state_q <= (in_last || last_d) ? ST_IDLE : ST_RUN;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // S1: operands for the multiplier bank, held while stalled so mul_r stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      mul_a_q    <= '0;
      tw_q       <= 5'd0;
      s1_byp_q   <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        mul_a_q   <= in_data;
        tw_q      <= k_d;
        s1_byp_q  <= byp_d;
        s1_last_q <= last_d;
      end
    end
  end

  // S2: registered output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data_q <= s1_byp_q ? mul_a_q : mul_r;
      end
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_tw_idx = tw_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft64_twiddle_sched.sv
// Directed bench for fft64_twiddle_sched: a stand-in multiplier, a scoreboard of expected
// outputs and hand-computed twiddle exponents at selected indices.
module tb_fft64_twiddle_sched;

  logic        clk;
  logic        rst;
  logic [2:0]  cfg_stage;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] mul_a;
  logic [4:0]  mul_tw_idx;
  logic [31:0] mul_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int rdy_mode = 0;
  int mdl_n = 0;
  int mdl_s = 0;
  logic [32:0] exp_q[$];
  logic [4:0]  tw_log[$];
  logic [32:0] mon_e;

  fft64_twiddle_sched #(.DW(32)) dut (
    .clk(clk), .rst(rst), .cfg_stage(cfg_stage),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mul_a(mul_a), .mul_tw_idx(mul_tw_idx), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_err(frame_err)
  );

  // Stand-in multiplier: differs from mul_a for every k, including k=0.
  assign mul_r = ~mul_a ^ {3'b000, mul_tw_idx, 8'h00, 3'b000, mul_tw_idx, 8'h00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input int f, input int i);
    return 32'(((f & 255) << 24) | ((i & 255) << 16) | ((i * 257 + 32'hC3A5) & 32'hFFFF));
  endfunction

  // Second half of each group of size 2*h (h = 32>>s) gets k = (n mod h) << s.
  function automatic logic [4:0] mdl_k(input int n, input int s);
    int h;
    h = 32 >> s;
    if ((n & h) != 0) return 5'((n & (h - 1)) << s);
    else return 5'd0;
  endfunction

  function automatic logic [31:0] exp_out(input logic [31:0] d, input logic [4:0] k);
    if (k == 5'd0) return d;
    else return ~d ^ {3'b000, k, 8'h00, 3'b000, k, 8'h00};
  endfunction

  function automatic logic pick_ready();
    if (rdy_mode == 0) return 1'b1;
    else if (rdy_mode == 1) return 1'($urandom_range(1, 0));
    else return 1'b0;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] cfg);
    logic acc;
    int guard;
    logic [4:0] k;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      out_ready = pick_ready();
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      cfg_stage = cfg;
      #1 acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (mdl_n == 0) mdl_s = (cfg > 3'd5) ? 5 : int'(cfg);
      k = mdl_k(mdl_n, mdl_s);
      tw_log.push_back(mul_tw_idx);
      check_eq("tw_idx", 32'(mul_tw_idx), 32'(k));
      exp_q.push_back({(mdl_n == 63), exp_out(d, k)});
      mdl_n = (last || mdl_n == 63) ? 0 : mdl_n + 1;
    end
  endtask

  task automatic send_frame(input int f, input int cnt, input logic [2:0] c0,
                            input logic [2:0] c1, input int chg, input int lastpos);
    tw_log.delete();
    for (int i = 0; i < cnt; i++) begin
      send_beat(mk_data(f, i), (i == lastpos), (i < chg) ? c0 : c1);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 1000) begin
      @(negedge clk);
      out_ready = pick_ready();
      in_valid  = 1'b0;
      g++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: compares every completed output handshake against the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (frame_err) err_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_data", out_data, mon_e[31:0]);
          check_eq("out_last", 32'(out_last), 32'(mon_e[32]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d outputs pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cfg_stage = 3'd0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_mul_a", mul_a, 32'd0);
    check_eq("rst_tw_idx", 32'(mul_tw_idx), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Stage 0 frame, with first-output latency checked by hand.
    rdy_mode = 0;
    tw_log.delete();
    send_beat(mk_data(0, 0), 1'b0, 3'd0);
    check_eq("lat_not_yet", 32'(out_valid), 32'd0);
    send_beat(mk_data(0, 1), 1'b0, 3'd0);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_data", out_data, mk_data(0, 0));
    for (int i = 2; i < 64; i++) send_beat(mk_data(0, i), (i == 63), 3'd0);
    drain();
    check_eq("s0_n0", 32'(tw_log[0]), 32'd0);
    check_eq("s0_n32", 32'(tw_log[32]), 32'd0);
    check_eq("s0_n33", 32'(tw_log[33]), 32'd1);
    check_eq("s0_n63", 32'(tw_log[63]), 32'd31);

    // Stage 2 frame.
    send_frame(1, 64, 3'd2, 3'd2, 99, 63);
    drain();
    check_eq("s2_n13", 32'(tw_log[13]), 32'd20);
    check_eq("s2_n8", 32'(tw_log[8]), 32'd0);
    check_eq("s2_n15", 32'(tw_log[15]), 32'd28);
    check_eq("s2_n24", 32'(tw_log[24]), 32'd0);
    check_eq("s2_n31", 32'(tw_log[31]), 32'd28);

    // cfg 7 behaves as stage 5: everything bypasses.
    send_frame(2, 64, 3'd7, 3'd7, 99, 63);
    drain();
    check_eq("s5_n1", 32'(tw_log[1]), 32'd0);
    check_eq("s5_n63", 32'(tw_log[63]), 32'd0);

    // Three back-to-back frames under random backpressure, cfg changing mid-frame.
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) send_frame(3 + f, 64, 3'(f + 1), 3'd4, 20, 63);
    drain();
    check_eq("stall_s3_n5", 32'(tw_log[5]), 32'd8);
    check_eq("no_err_yet", 32'(err_seen), 32'd0);

    // Early in_last on n=40, then a fresh stage-3 frame.
    rdy_mode = 0;
    send_frame(6, 41, 3'd1, 3'd1, 99, 40);
    check_eq("err_pulse", 32'(frame_err), 32'd1);
    send_frame(7, 64, 3'd3, 3'd3, 99, 63);
    check_eq("err_cleared", 32'(frame_err), 32'd0);
    drain();
    check_eq("resync_s3_n5", 32'(tw_log[5]), 32'd8);
    check_eq("resync_s3_n4", 32'(tw_log[4]), 32'd0);
    check_eq("err_once", 32'(err_seen), 32'd1);

    // Reset with two beats in flight.
    rdy_mode = 2;
    send_frame(8, 2, 3'd2, 3'd2, 99, 63);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", out_data, 32'd0);
    check_eq("mid_rst_tw", 32'(mul_tw_idx), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    mdl_n = 0;
    mdl_s = 0;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("no_stale_valid", 32'(out_valid), 32'd0);
    send_frame(9, 64, 3'd4, 3'd4, 99, 63);
    drain();
    check_eq("post_rst_n3", 32'(tw_log[3]), 32'd16);
    check_eq("post_rst_n2", 32'(tw_log[2]), 32'd0);
    check_eq("final_err_count", 32'(err_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
